// File: rtl/filtro_pkg.sv
// Shared types and sizing helpers for the fixed-point filter sequencer.
package filtro_pkg;

  localparam int unsigned N_DEF    = 24;
  localparam int unsigned FRAC_DEF = 10;
  localparam int unsigned TAPS_DEF = 5;

  function automatic int unsigned idx_w(input int unsigned taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

  function automatic int unsigned acc_w(input int unsigned n, input int unsigned taps);
    return 2 * n + idx_w(taps);
  endfunction

  localparam int unsigned ACC_W = acc_w(N_DEF, TAPS_DEF);

  typedef enum logic [1:0] {IDLE, MAC, SALIDA} estado_t;

endpackage

// File: rtl/secuenciador_filtro_trunc_sat.sv
// Accumulator scaling: arithmetic shift by FRAC, then narrow to N bits.
// FILTRO_SAT_EN selects saturation; otherwise the low N bits wrap.
module trunc_sat #(
  parameter int unsigned N     = 24,
  parameter int unsigned FRAC  = 10,
  parameter int unsigned ACC_W = 51
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [N-1:0]     y
);

  logic signed [ACC_W-1:0] desplazado;

  always_comb desplazado = acc >>> FRAC;

`ifdef FILTRO_SAT_EN
  // In range only when every bit from N-1 upward equals the sign bit.
  always_comb begin
    y = desplazado[N-1:0];
    if (desplazado[ACC_W-1:N-1] != {(ACC_W-N+1){desplazado[ACC_W-1]}})
      y = desplazado[ACC_W-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  end
`else
  logic unused_altos;

  always_comb y = desplazado[N-1:0];
  always_comb unused_altos = ^desplazado[ACC_W-1:N];
`endif

endmodule

// File: rtl/secuenciador_filtro.sv
// Sample-in / MAC / output sequencer for the signed fixed-point FIR datapath.
// Optional output saturation via FILTRO_SAT_EN (see trunc_sat).
module secuenciador_filtro
  import filtro_pkg::*;
#(
  parameter int unsigned N    = N_DEF,
  parameter int unsigned FRAC = FRAC_DEF,
  parameter int unsigned TAPS = TAPS_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [N-1:0]     muestra_in,
  input  logic                    muestra_valid,
  output logic                    listo,
  input  logic                    coef_we,
  input  logic [idx_w(TAPS)-1:0]  coef_addr,
  input  logic signed [N-1:0]     coef_data,
  output logic signed [N-1:0]     salida,
  output logic                    salida_valid,
  output logic                    ocupado
);

  localparam int unsigned IW = idx_w(TAPS);
  localparam int unsigned AW = acc_w(N, TAPS);

  estado_t              estado;
  logic signed [N-1:0]  x [TAPS];
  logic signed [N-1:0]  c [TAPS];
  logic signed [AW-1:0] acc;
  logic [IW-1:0]        idx;
  logic signed [2*N-1:0] prod;
  logic signed [N-1:0]  escalado;

  always_comb prod = x[idx] * c[idx];

  trunc_sat #(
    .N     (N),
    .FRAC  (FRAC),
    .ACC_W (AW)
  ) u_trunc_sat (
    .acc (acc),
    .y   (escalado)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado <= IDLE;
      for (int unsigned k = 0; k < TAPS; k++) begin
        x[k] <= '0;
        c[k] <= '0;
      end
      acc          <= '0;
      idx          <= '0;
      salida       <= '0;
      salida_valid <= 1'b0;
      listo        <= 1'b1;
      ocupado      <= 1'b0;
    end else begin
      salida_valid <= 1'b0;
      case (estado)
        IDLE: begin
          // Coefficient bank is writable only here, so it is frozen during a computation.
          if (coef_we && (int'(coef_addr) < TAPS))
            c[coef_addr] <= coef_data;
          if (muestra_valid) begin
            x[0] <= muestra_in;
            for (int unsigned k = 1; k < TAPS; k++)
              x[k] <= x[k-1];
            acc     <= '0;
            idx     <= '0;
            estado  <= MAC;
            listo   <= 1'b0;
            ocupado <= 1'b1;
          end
        end
        MAC: begin
          acc <= acc + AW'(prod);
          idx <= idx + IW'(1);
          if (idx == IW'(TAPS - 1))
            estado <= SALIDA;
        end
        SALIDA: begin
          salida       <= escalado;
          salida_valid <= 1'b1;
          estado       <= IDLE;
          listo        <= 1'b1;
          ocupado      <= 1'b0;
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_filtro.sv
// Directed self-checking bench for secuenciador_filtro (N=24, FRAC=10, TAPS=5).
module tb_secuenciador_filtro;

  localparam int N = 24;

  logic                clk = 1'b0;
  logic                reset;
  logic signed [N-1:0] muestra_in;
  logic                muestra_valid;
  logic                listo;
  logic                coef_we;
  logic [2:0]          coef_addr;
  logic signed [N-1:0] coef_data;
  logic signed [N-1:0] salida;
  logic                salida_valid;
  logic                ocupado;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  secuenciador_filtro dut (
    .clk           (clk),
    .reset         (reset),
    .muestra_in    (muestra_in),
    .muestra_valid (muestra_valid),
    .listo         (listo),
    .coef_we       (coef_we),
    .coef_addr     (coef_addr),
    .coef_data     (coef_data),
    .salida        (salida),
    .salida_valid  (salida_valid),
    .ocupado       (ocupado)
  );

  task automatic write_coef(input logic [2:0] a, input logic signed [N-1:0] d);
    coef_addr = a;
    coef_data = d;
    coef_we   = 1'b1;
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  // Offers one sample (optionally with a same-cycle coefficient write) and
  // returns the next output and its latency in edges after acceptance.
  task automatic run_sample(input logic signed [N-1:0] v, input logic we,
                            input logic [2:0] a, input logic signed [N-1:0] d,
                            output logic signed [N-1:0] y, output int lat);
    int w;
    w = 0;
    while (!listo && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    muestra_in    = v;
    muestra_valid = 1'b1;
    coef_we       = we;
    coef_addr     = a;
    coef_data     = d;
    @(posedge clk); #1;
    muestra_valid = 1'b0;
    coef_we       = 1'b0;
    lat = -1;
    y   = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (salida_valid) begin
        lat = i;
        y   = salida;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic signed [N-1:0] y;
    int lat;
    reset = 1'b1; muestra_valid = 1'b0; muestra_in = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (salida !== 24'sd0) begin errors++; $display("FAIL reset_salida got %0d want 0", salida); end
    checks++; if (salida_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", salida_valid); end
    checks++; if (listo !== 1'b1) begin errors++; $display("FAIL reset_listo got %b want 1", listo); end
    checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL reset_ocupado got %b want 0", ocupado); end
    reset = 1'b0;
    @(posedge clk); #1;
    run_sample(24'sd0, 1'b0, 3'd0, 24'sd0, y, lat);
    checks++; if (y !== 24'sd0) begin errors++; $display("FAIL reset_zero_sample got %0d want 0", y); end
    checks++; if (lat !== 6) begin errors++; $display("FAIL reset_zero_latency got %0d want 6", lat); end
  endtask

  task automatic test_impulse();
    int coefs [5] = '{1024, 2048, -1024, 512, 0};
    int ins   [5] = '{1024, 0, 0, 0, 0};
    int exps  [5] = '{1024, 2048, -1024, 512, 0};
    logic signed [N-1:0] y, e;
    int lat;
    for (int i = 0; i < 5; i++) write_coef(3'(i), N'(coefs[i]));
    for (int i = 0; i < 5; i++) begin
      run_sample(N'(ins[i]), 1'b0, 3'd0, 24'sd0, y, lat);
      e = N'(exps[i]);
      checks++; if (y !== e) begin errors++; $display("FAIL impulse_out[%0d] got %0d want %0d", i, y, e); end
      checks++; if (lat !== 6) begin errors++; $display("FAIL impulse_latency[%0d] got %0d want 6", i, lat); end
    end
  endtask

  task automatic test_sign();
    logic signed [N-1:0] y;
    int lat;
    write_coef(3'd0, -24'sd1024);
    for (int i = 1; i < 5; i++) write_coef(3'(i), 24'sd0);
    run_sample(-24'sd2048, 1'b0, 3'd0, 24'sd0, y, lat);
    checks++; if (y !== 24'sd2048) begin errors++; $display("FAIL sign_neg_neg got %0d want 2048", y); end
    write_coef(3'd0, 24'sd1);
    run_sample(-24'sd1, 1'b0, 3'd0, 24'sd0, y, lat);
    checks++; if (y !== 24'hFFFFFF) begin errors++; $display("FAIL sign_floor got %h want ffffff", y); end
  endtask

  task automatic test_same_cycle();
    logic signed [N-1:0] y;
    int lat;
    // x becomes {512,-1,-2048,0,0}; c0 rewritten to 2048 on the acceptance edge.
    run_sample(24'sd512, 1'b1, 3'd0, 24'sd2048, y, lat);
    checks++; if (y !== 24'sd1024) begin errors++; $display("FAIL same_cycle_coef got %0d want 1024", y); end
  endtask

  task automatic test_overflow();
    logic signed [N-1:0] y, e;
    int lat;
`ifdef FILTRO_SAT_EN
    e = 24'h7FFFFF;
`else
    e = 24'h000000;
`endif
    for (int i = 0; i < 5; i++) write_coef(3'(i), 24'sd4194304);
    for (int i = 0; i < 5; i++) run_sample(24'sd4194304, 1'b0, 3'd0, 24'sd0, y, lat);
    checks++; if (y !== e) begin errors++; $display("FAIL overflow_out got %h want %h", y, e); end
  endtask

  task automatic test_back_to_back();
    int acc_t [$];
    logic signed [N-1:0] outs [$];
    int since, d;
    logic l_prev;
    write_coef(3'd0, 24'sd1024);
    for (int i = 1; i < 5; i++) write_coef(3'(i), 24'sd0);
    since = 0;
    d = 100;
    muestra_in = N'(d);
    muestra_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && outs.size() < 4; cyc++) begin
      l_prev    = listo;
      coef_addr = 3'd0;
      coef_data = 24'sd0;
      coef_we   = (acc_t.size() == 1 && since >= 1 && since <= 3);
      if (coef_we) begin
        checks++; if (ocupado !== 1'b1) begin errors++; $display("FAIL busy_during_we got %b want 1", ocupado); end
      end
      @(posedge clk); #1;
      if (l_prev && muestra_valid) begin
        acc_t.push_back(cyc);
        d++;
        muestra_in = N'(d);
        since = 0;
      end else begin
        since++;
      end
      if (salida_valid) begin
        outs.push_back(salida);
        if (outs.size() == 4) muestra_valid = 1'b0;
      end
    end
    coef_we = 1'b0;
    muestra_valid = 1'b0;
    checks++; if (acc_t.size() !== 4) begin errors++; $display("FAIL b2b_accept_count got %0d want 4", acc_t.size()); end
    for (int i = 1; i < acc_t.size(); i++) begin
      checks++; if (acc_t[i] - acc_t[i-1] !== 7) begin errors++; $display("FAIL b2b_interval[%0d] got %0d want 7", i, acc_t[i] - acc_t[i-1]); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= outs.size() || outs[i] !== N'(100 + i)) begin
        errors++;
        $display("FAIL b2b_out[%0d] got %0d want %0d", i, (i < outs.size()) ? outs[i] : 'x, 100 + i);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic signed [N-1:0] y;
    int lat, seen;
    seen = 0;
    muestra_in = 24'sd7;
    muestra_valid = 1'b1;
    @(posedge clk); #1;
    muestra_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; if (salida_valid) seen++; end
    reset = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (salida_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_pulse got %0d pulses want 0", seen); end
    checks++; if (listo !== 1'b1) begin errors++; $display("FAIL midreset_listo got %b want 1", listo); end
    checks++; if (salida !== 24'sd0) begin errors++; $display("FAIL midreset_salida got %0d want 0", salida); end
    run_sample(24'sd1024, 1'b0, 3'd0, 24'sd0, y, lat);
    checks++; if (y !== 24'sd0) begin errors++; $display("FAIL midreset_coef_cleared got %0d want 0", y); end
    for (int i = 0; i < 5; i++) write_coef(3'(i), 24'sd1024);
    // Delay line is now {0,1024,0,0,0} only if reset cleared the old samples.
    run_sample(24'sd0, 1'b0, 3'd0, 24'sd0, y, lat);
    checks++; if (y !== 24'sd1024) begin errors++; $display("FAIL midreset_line_cleared got %0d want 1024", y); end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_sign();
    test_same_cycle();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
